// File: rtl/window_gen_pkg.sv
// Shared types and helpers for the 3x3 window generator.
package window_gen_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        RUN      = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    // Byte position of window element (r,c); r=0 is the oldest row, c=0 the oldest column.
    function automatic int idx(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/window_gen_3x3_shift3.sv
// Three-stage pixel shift register for one window row; taps_o[0] holds the oldest column.
module win_shift3
    import window_gen_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [PIX_W-1:0]      din_i,
    output logic [2:0][PIX_W-1:0] taps_o
);

    logic [2:0][PIX_W-1:0] taps_q;
    logic [2:0][PIX_W-1:0] taps_d;

    always_comb begin
        taps_d = taps_q;
        if (en_i) begin
            taps_d = {din_i, taps_q[2], taps_q[1]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: these taps drive win_data directly, so unlike RAM storage they are reset to give a defined window.
        if (reset) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 window generator driving two external FWFT line-delay FIFOs.
// Optional start-of-frame checking is built when WINDOW_GEN_SOF_CHECK_EN is defined.
module window_gen_3x3
    import window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int RST_HOLD   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_sof,
    output logic               in_ready,
    output logic               f0_wre,
    output logic [PIX_W-1:0]   f0_din,
    output logic               f0_rde,
    input  logic [PIX_W-1:0]   f0_dout,
    output logic               f1_wre,
    output logic [PIX_W-1:0]   f1_din,
    output logic               f1_rde,
    input  logic [PIX_W-1:0]   f1_dout,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win_data
`ifdef WINDOW_GEN_SOF_CHECK_EN
    ,
    output logic               sof_err
`endif
);

    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int CNT_MAX = (RST_HOLD > IMG_WIDTH) ? RST_HOLD : IMG_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] LINE_LEN  = CNT_W'(IMG_WIDTH);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_valid_q, win_valid_d;

    logic             accept;
    logic             take;
    logic             row_ge1, row_ge2, col_ge2;
    logic             last_pix;
    logic [CNT_W-1:0] f0_len, f1_len;

    logic [2:0][PIX_W-1:0] tap_old, tap_mid, tap_new;

    assign row_ge1  = (row_q != '0);
    assign row_ge2  = (row_q >= ROW_W'(2));
    assign col_ge2  = (col_q >= COL_W'(2));
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef WINDOW_GEN_SOF_CHECK_EN
    logic             sof_err_q, sof_err_d;
    logic [CNT_W-1:0] f0_len_q, f0_len_d;
    logic [CNT_W-1:0] f1_len_q, f1_len_d;
    logic             sof_bad;

    assign sof_bad = pix_sof && ((row_q != '0) || (col_q != '0));
    assign f0_len  = f0_len_q;
    assign f1_len  = f1_len_q;
    assign sof_err = sof_err_q;
`else
    logic unused_sof;

    assign unused_sof = pix_sof;
    assign f0_len     = LINE_LEN;
    assign f1_len     = LINE_LEN;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = 1'b0;
        in_ready    = 1'b0;
        accept      = 1'b0;
        take        = 1'b0;
        f0_wre      = 1'b0;
        f0_rde      = 1'b0;
        f1_wre      = 1'b0;
        f1_rde      = 1'b0;
        f0_din      = pix_data;
        f1_din      = f0_dout;
`ifdef WINDOW_GEN_SOF_CHECK_EN
        sof_err_d   = sof_err_q;
        f0_len_d    = f0_len_q;
        f1_len_d    = f1_len_q;
`endif

        unique case (state_q)
            RST_WAIT: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                in_ready = 1'b1;
                accept   = pix_valid;
`ifdef WINDOW_GEN_SOF_CHECK_EN
                // A misplaced SOF drops the pixel and drains exactly what the FIFOs hold at this point.
                if (accept && sof_bad) begin
                    sof_err_d = 1'b1;
                    state_d   = FLUSH;
                    cnt_d     = '0;
                    row_d     = '0;
                    col_d     = '0;
                    f0_len_d  = (row_q == '0) ? CNT_W'(col_q) : LINE_LEN;
                    f1_len_d  = (row_q == '0)        ? '0 :
                                (row_q == ROW_W'(1)) ? CNT_W'(col_q) : LINE_LEN;
                end else begin
                    take = accept;
                end
`else
                take = accept;
`endif
                if (take) begin
                    f0_wre      = 1'b1;
                    f0_rde      = row_ge1;
                    f1_wre      = row_ge1;
                    f1_rde      = row_ge2;
                    win_valid_d = row_ge2 && col_ge2;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pix) begin
                        state_d  = FLUSH;
                        cnt_d    = '0;
`ifdef WINDOW_GEN_SOF_CHECK_EN
                        f0_len_d = LINE_LEN;
                        f1_len_d = LINE_LEN;
`endif
                    end
                end
            end

            FLUSH: begin
                f0_rde = 1'b1;
                f1_rde = (cnt_q < f1_len);
                if (cnt_q == f0_len - 1'b1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= RST_WAIT;
            cnt_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
        end
    end

`ifdef WINDOW_GEN_SOF_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sof_err_q <= 1'b0;
            f0_len_q  <= LINE_LEN;
            f1_len_q  <= LINE_LEN;
        end else begin
            sof_err_q <= sof_err_d;
            f0_len_q  <= f0_len_d;
            f1_len_q  <= f1_len_d;
        end
    end
`endif

    win_shift3 u_row_old (
        .clk    (clk),
        .reset  (reset),
        .en_i   (take),
        .din_i  (f1_dout),
        .taps_o (tap_old)
    );

    win_shift3 u_row_mid (
        .clk    (clk),
        .reset  (reset),
        .en_i   (take),
        .din_i  (f0_dout),
        .taps_o (tap_mid)
    );

    win_shift3 u_row_new (
        .clk    (clk),
        .reset  (reset),
        .en_i   (take),
        .din_i  (pix_data),
        .taps_o (tap_new)
    );

    always_comb begin
        win_data = '0;
        for (int c = 0; c < 3; c++) begin
            win_data[PIX_W*idx(0, c) +: PIX_W] = tap_old[c];
            win_data[PIX_W*idx(1, c) +: PIX_W] = tap_mid[c];
            win_data[PIX_W*idx(2, c) +: PIX_W] = tap_new[c];
        end
    end

    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 with behavioural FWFT line FIFOs and a window scoreboard.
module tb_window_gen_3x3;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int HOLD = 16;
    localparam int NWIN = (H - 2) * (W - 2);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        pix_sof = 1'b0;
    logic        in_ready;
    logic        f0_wre, f0_rde, f1_wre, f1_rde;
    logic [7:0]  f0_din, f1_din, f0_dout, f1_dout;
    logic        win_valid;
    logic [71:0] win_data;
`ifdef WINDOW_GEN_SOF_CHECK_EN
    logic        sof_err;
`endif

    int          checks = 0;
    int          failures = 0;
    int          frame_windows = 0;
    logic [71:0] exp_q [$];

    always #5 clk = ~clk;

    window_gen_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .RST_HOLD   (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .in_ready  (in_ready),
        .f0_wre    (f0_wre),
        .f0_din    (f0_din),
        .f0_rde    (f0_rde),
        .f0_dout   (f0_dout),
        .f1_wre    (f1_wre),
        .f1_din    (f1_din),
        .f1_rde    (f1_rde),
        .f1_dout   (f1_dout),
        .win_valid (win_valid),
        .win_data  (win_data)
`ifdef WINDOW_GEN_SOF_CHECK_EN
        ,
        .sof_err   (sof_err)
`endif
    );

    // Behavioural FWFT FIFOs sharing the block reset; flag underflow and occupancy above one line.
    logic [7:0] fmem [2][16];
    int         fwp [2];
    int         frp [2];
    int         fcnt [2];
    bit         funf [2];
    bit         fovf [2];
    logic [1:0] fwre, frde;
    logic [7:0] fdin [2];

    assign fwre    = {f1_wre, f0_wre};
    assign frde    = {f1_rde, f0_rde};
    assign fdin[0] = f0_din;
    assign fdin[1] = f1_din;
    assign f0_dout = fmem[0][frp[0]];
    assign f1_dout = fmem[1][frp[1]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                fwp[i]  <= 0;
                frp[i]  <= 0;
                fcnt[i] <= 0;
            end else begin
                if (fwre[i]) begin
                    fmem[i][fwp[i]] <= fdin[i];
                    fwp[i]          <= (fwp[i] + 1) % 16;
                end
                if (frde[i]) begin
                    frp[i] <= (frp[i] + 1) % 16;
                    if (fcnt[i] == 0) funf[i] <= 1'b1;
                end
                fcnt[i] <= fcnt[i] + int'(fwre[i]) - int'(frde[i]);
                if (fcnt[i] + int'(fwre[i]) - int'(frde[i]) > W) fovf[i] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] expected_window(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                w[8*(rr*3+cc) +: 8] = 8'((r - 2 + rr) * 16 + (c - 2 + cc));
            end
        end
        return w;
    endfunction

    // One clock; outputs sampled 1 time unit after the edge. acc says whether that edge accepted a pixel.
    task automatic tick(input bit acc);
        logic [71:0] exp_w;
        @(posedge clk);
        #1;
        if (win_valid) begin
            frame_windows++;
            check("win_after_accept", 72'(acc), 72'(1));
            check("win_expected", 72'(exp_q.size() != 0), 72'(1));
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("win_data", win_data, exp_w);
            end
        end
    endtask

    task automatic send_pixel(input int r, input int c, input bit sof, input bit discard);
        int waited;
        waited    = 0;
        pix_valid = 1'b1;
        pix_data  = 8'(r * 16 + c);
        pix_sof   = sof;
        while (!in_ready && waited < 100) begin
            tick(1'b0);
            waited++;
        end
        if (waited >= 100) check("accept_timeout", 72'(in_ready), 72'(1));
        if (!discard && r >= 2 && c >= 2) exp_q.push_back(expected_window(r, c));
        tick(1'b1);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic flush_check(input int len0, input int len1);
        int n;
        n = 0;
        while (!in_ready && n < 4 * W) begin
            check("flush_enables", 72'({f0_rde, f1_rde, f0_wre, f1_wre}),
                  72'({1'b1, (n < len1), 2'b00}));
            n++;
            tick(1'b0);
        end
        check("flush_cycles", 72'(n), 72'(len0));
        check("fifo0_empty", 72'(fcnt[0]), 72'(0));
        check("fifo1_empty", 72'(fcnt[1]), 72'(0));
        check("fifo_underflow", 72'({funf[1], funf[0]}), 72'(0));
        check("fifo_overflow", 72'({fovf[1], fovf[0]}), 72'(0));
    endtask

    task automatic run_frame(input bit bubbles);
        frame_windows = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel(r, c, (r == 0 && c == 0), 1'b0);
                if (bubbles && !(r == H - 1 && c == W - 1)) tick(1'b0);
            end
        end
        flush_check(W, W);
        check("frame_windows", 72'(frame_windows), 72'(NWIN));
        check("scoreboard_drained", 72'(exp_q.size()), 72'(0));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        tick(1'b0);
        tick(1'b0);
        exp_q.delete();
        check("rst_in_ready", 72'(in_ready), 72'(0));
        check("rst_fifo_en", 72'({f0_wre, f0_rde, f1_wre, f1_rde}), 72'(0));
        check("rst_win_valid", 72'(win_valid), 72'(0));
        check("rst_win_data", win_data, 72'(0));
`ifdef WINDOW_GEN_SOF_CHECK_EN
        check("rst_sof_err", 72'(sof_err), 72'(0));
`endif
        reset = 1'b0;
        for (int k = 1; k <= HOLD; k++) begin
            tick(1'b0);
            check("hold_in_ready", 72'(in_ready), 72'(k == HOLD));
            check("hold_fifo_en", 72'({f0_wre, f0_rde, f1_wre, f1_rde}), 72'(0));
        end
        check("rst_fifo_cleared", 72'(fcnt[0] + fcnt[1]), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset release and hold-off.
        do_reset();

        // Two identical frames with continuous valid, then one with bubbles.
        run_frame(1'b0);
        run_frame(1'b0);
        run_frame(1'b1);
`ifdef WINDOW_GEN_SOF_CHECK_EN
        check("sof_err_clean", 72'(sof_err), 72'(0));
`endif

        // Reset in the middle of a frame at pixel 0x15, then a fresh frame.
        for (int i = 0; i < W + 6; i++) send_pixel(i / W, i % W, (i == 0), 1'b0);
        do_reset();
        run_frame(1'b0);

`ifdef WINDOW_GEN_SOF_CHECK_EN
        // Misplaced SOF on pixel 0x13: pixel dropped, partial FIFO contents drained.
        for (int i = 0; i < W + 3; i++) send_pixel(i / W, i % W, (i == 0), 1'b0);
        send_pixel(1, 3, 1'b1, 1'b1);
        check("sof_err_set", 72'(sof_err), 72'(1));
        flush_check(W, 3);
        run_frame(1'b0);
        check("sof_err_sticky", 72'(sof_err), 72'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream/around-stage of the filter2d line-delay FIFOs: accepts the raster pixel stream, drives two external 8-bit FWFT line-delay FIFOs (write side and read side), and emits a 3x3 pixel window per interior pixel to the 2D filter kernel.
- Owns the row/column counters, the line-delay sequencing, end-of-frame FIFO drain and the post-reset hold-off required by the FIFOs' internal reset synchroniser.

Parameters:
- IMG_WIDTH, 640, pixels per line; legal range 3..2048, bounded by FIFO depth.
- IMG_HEIGHT, 480, lines per frame; minimum 3.
- RST_HOLD, 16, cycles `in_ready` stays low after `reset` deasserts; covers the FIFO reset sync and reset-busy time.

Ports:
- clk  in  1  single clock for block and both FIFOs
- reset  in  1  synchronous, active-high
- pix_valid  in  1  upstream pixel valid
- pix_data  in  8  upstream pixel
- pix_sof  in  1  start of frame, qualified by pix_valid
- in_ready  out  1  block accepts pixel this cycle
- f0_wre  out  1  line FIFO 0 write enable
- f0_din  out  8  line FIFO 0 write data
- f0_rde  out  1  line FIFO 0 read enable
- f0_dout  in  8  line FIFO 0 FWFT head
- f1_wre  out  1  line FIFO 1 write enable
- f1_din  out  8  line FIFO 1 write data
- f1_rde  out  1  line FIFO 1 read enable
- f1_dout  in  8  line FIFO 1 FWFT head
- win_valid  out  1  window valid; no backpressure
- win_data  out  72  window; byte k=r*3+c at [8k+7:8k], r=0 oldest row, c=0 oldest column
- sof_err  out  1  sticky sync error; present only with the optional feature

Behaviour:
- Reset values:
  - state=RST_WAIT; row=col=0.
  - in_ready, all FIFO enables, win_valid and sof_err are 0.
  - win_data and shift registers are 0.
- FSM:
  - RST_WAIT → RUN after RST_HOLD cycles following reset deassert.
  - RUN → FLUSH on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - FLUSH → RUN after IMG_WIDTH cycles.
- in_ready = (state==RUN). Accept = pix_valid & in_ready. Upstream holds data while in_ready is low.
- FIFO control on accept, combinational in the same cycle:
  - f0_wre=1, f0_din=pix_data.
  - f0_rde=f1_wre=(row>=1), f1_din=f0_dout.
  - f1_rde=(row>=2).
- Taps:
  - current row = pix_data.
  - previous row = f0_dout.
  - two rows back = f1_dout.
  - Each tap feeds a 3-deep column shift register advanced only on accept.
- Counters on accept:
  - col increments and wraps at IMG_WIDTH-1 to 0.
  - row increments on col wrap and wraps at IMG_HEIGHT-1 to 0.
- Output timing:
  - win_valid is registered: 1 in the cycle after an accept with row>=2 and col>=2; else 0.
  - Window is centred on pixel (row-1, col-1).
  - Latency is 1 cycle from the accept of pixel (r,c) to the window centred on (r-1,c-1).
  - No windows for border pixels.
- FIFO occupancy:
  - At frame end each FIFO holds exactly IMG_WIDTH entries.
  - FLUSH asserts f0_rde=f1_rde=1 for IMG_WIDTH cycles, with no writes and win_valid=0.
  - Both FIFOs are then empty.
- FIFOs never exceed IMG_WIDTH entries; no full/empty flag is required.
- Reset mid-frame: all state returns to reset values; FIFOs are cleared by the shared reset.
- Gaps in pix_valid: no state advance; outputs hold, except that win_valid drops after its single-cycle pulse.

Optional Feature:
- WINDOW_GEN_SOF_CHECK_EN defined:
  - An accept with pix_sof=1 while (row,col)!=(0,0) sets sof_err (sticky until reset).
  - That pixel is discarded (no FIFO write).
  - FSM enters FLUSH, draining the current FIFO occupancy computed from row/col.
  - FSM then returns to RUN expecting SOF.
  - pix_sof=0 at (0,0) is accepted without error.
- WINDOW_GEN_SOF_CHECK_EN undefined:
  - pix_sof is ignored.
  - sof_err port is absent.

Decomposition:
- window_gen_pkg:
  - PIX_W=8 and the state enum {RST_WAIT, RUN, FLUSH}.
  - Window byte-index function idx(r,c)=r*3+c.
- Sub-module win_shift3: 3-stage 8-bit shift register with enable, instantiated three times (one per row tap).

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=4, pixel value = row*16+col, continuous pix_valid unless stated):
- Reset release: in_ready stays 0 for 16 cycles and rises on cycle 17; no FIFO enables toggle before then.
- Full frame: win_valid pulses 12 times (rows 2..3, cols 2..7). First window after pixel 0x22 has win_data bytes 00,01,02,10,11,12,20,21,22 for k=0..8.
- Frame end: after pixel 0x37, in_ready=0 and f0_rde=f1_rde=1 for exactly 8 cycles. A second identical frame then produces identical windows.
- Bubbles: pix_valid toggling every other cycle yields the same 12 windows in the same order. win_valid is never asserted on consecutive idle cycles.
- Mid-frame reset at pixel 0x15: after a 16-cycle hold-off, a new frame produces correct windows starting from 00,01,02.
- WINDOW_GEN_SOF_CHECK_EN: pix_sof=1 on pixel 0x13 sets sof_err=1 and forces a flush. The next frame yields correct windows while sof_err stays 1.
